sd_tagbuf2: RTL and testbench

Two-entry srdy/drdy output buffer that sits directly downstream of the 2-input weighted-round-robin mux. It registers the mux output with a 1-bit source tag derived from the mux grant vector, and breaks the combinational drdy path back into the arbiter. It also keeps per-source saturating transfer counters and a sticky grant-error flag, so the arbiter's weight conformance can be observed in-system.

---
 rtl/sd_tagbuf2.sv | 155 +++++++++++++++
 tb/tb_sd_tagbuf2.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_tagbuf2.sv
// sd_tagbuf2: two-entry srdy/drdy output buffer for the 2-input WRR mux.
// Each beat is stored with a 1-bit source tag decoded from the grant vector.
// Per-source saturating transfer counters and a sticky grant-error flag
// expose the arbiter's weight conformance.
module sd_tagbuf2 #(
    parameter int unsigned width  = 8,
    parameter int unsigned cnt_sz = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_srdy,
    output logic              c_drdy,
    input  logic [width-1:0]  c_data,
    input  logic [1:0]        c_grant,
    output logic              p_srdy,
    input  logic              p_drdy,
    output logic [width-1:0]  p_data,
    output logic              p_src,
    input  logic              cnt_clr,
    output logic [cnt_sz-1:0] cnt0,
    output logic [cnt_sz-1:0] cnt1,
    output logic              err_grant
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e state_q, state_d;

    logic             wr_ptr_q, rd_ptr_q;
    logic [width-1:0] data_q [2];
    logic             src_q  [2];

    logic [cnt_sz-1:0] cnt0_q, cnt0_d;
    logic [cnt_sz-1:0] cnt1_q, cnt1_d;
    logic              err_q, err_d;

    logic c_xfer, p_xfer;
    logic g_src, g_inc0, g_inc1, g_err;

    assign c_xfer = c_srdy & c_drdy;
    assign p_xfer = p_srdy & p_drdy;

    // Occupancy state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy next state from the two handshakes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (c_xfer) state_d = StOne;
            StOne: begin
                if (c_xfer && !p_xfer) begin
                    state_d = StFull;
                end else if (p_xfer && !c_xfer) begin
                    state_d = StEmpty;
                end
            end
            StFull:  if (p_xfer) state_d = StOne;
            default: state_d = StEmpty;
        endcase
    end

    // Handshake outputs decoded from registered state only, so c_drdy never
    // depends combinationally on p_drdy.
    always_comb begin
        c_drdy = (state_q != StFull);
        p_srdy = (state_q != StEmpty);
    end

    // Grant decode: non-one-hot grants are tagged as source 0 and flagged.
    always_comb begin
        g_src  = 1'b0;
        g_inc0 = 1'b0;
        g_inc1 = 1'b0;
        g_err  = 1'b0;
        unique case (c_grant)
            2'b01: g_inc0 = 1'b1;
            2'b10: begin
                g_src  = 1'b1;
                g_inc1 = 1'b1;
            end
            default: g_err = 1'b1;
        endcase
    end

    // Entry storage and pointers; no bypass, the head always comes from storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            data_q[0] <= '0;
            data_q[1] <= '0;
            src_q[0]  <= 1'b0;
            src_q[1]  <= 1'b0;
        end else begin
            if (c_xfer) begin
                data_q[wr_ptr_q] <= c_data;
                src_q[wr_ptr_q]  <= g_src;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (p_xfer) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign p_data = data_q[rd_ptr_q];
    assign p_src  = src_q[rd_ptr_q];

    // Counter and error-flag next state; clear wins over a same-cycle beat.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        err_d  = err_q;
        if (cnt_clr) begin
            cnt0_d = '0;
            cnt1_d = '0;
            err_d  = 1'b0;
        end else if (c_xfer) begin
            if (g_inc0 && (cnt0_q != {cnt_sz{1'b1}})) begin
                cnt0_d = cnt0_q + cnt_sz'(1);
            end
            if (g_inc1 && (cnt1_q != {cnt_sz{1'b1}})) begin
                cnt1_d = cnt1_q + cnt_sz'(1);
            end
            if (g_err) begin
                err_d = 1'b1;
            end
        end
    end

    // Counter and error-flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
            err_q  <= err_d;
        end
    end

    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;
    assign err_grant = err_q;

endmodule

// File: tb/tb_sd_tagbuf2.sv
// Testbench for sd_tagbuf2: scoreboard of {src, data} beats pushed on accept
// and popped on delivery, plus a counter model checked every cycle.
// A second instance with 2-bit counters covers saturation.
module tb_sd_tagbuf2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       c_srdy;
    logic [7:0] c_data;
    logic [1:0] c_grant;
    logic       p_drdy;
    logic       cnt_clr;

    logic        c_drdy, p_srdy, p_src, err_grant;
    logic [7:0]  p_data;
    logic [15:0] cnt0, cnt1;

    logic       c_drdy_n, p_srdy_n, p_src_n, err_grant_n;
    logic [7:0] p_data_n;
    logic [1:0] cnt0_n, cnt1_n;

    sd_tagbuf2 #(.width(8), .cnt_sz(16)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .c_srdy    (c_srdy),
        .c_drdy    (c_drdy),
        .c_data    (c_data),
        .c_grant   (c_grant),
        .p_srdy    (p_srdy),
        .p_drdy    (p_drdy),
        .p_data    (p_data),
        .p_src     (p_src),
        .cnt_clr   (cnt_clr),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .err_grant (err_grant)
    );

    sd_tagbuf2 #(.width(8), .cnt_sz(2)) u_dut_n (
        .clk       (clk),
        .reset     (reset),
        .c_srdy    (c_srdy),
        .c_drdy    (c_drdy_n),
        .c_data    (c_data),
        .c_grant   (c_grant),
        .p_srdy    (p_srdy_n),
        .p_drdy    (p_drdy),
        .p_data    (p_data_n),
        .p_src     (p_src_n),
        .cnt_clr   (cnt_clr),
        .cnt0      (cnt0_n),
        .cnt1      (cnt1_n),
        .err_grant (err_grant_n)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int n, input int max);
        return (n > max) ? max : n;
    endfunction

    // Scoreboard and counter model
    logic [8:0] sb[$];
    int   m_n0 = 0;
    int   m_n1 = 0;
    logic m_err = 1'b0;

    always @(negedge clk) begin
        logic [8:0] exp_beat;
        if (reset) begin
            sb.delete();
            m_n0  = 0;
            m_n1  = 0;
            m_err = 1'b0;
        end
        check_eq("c_drdy", 32'(c_drdy), 32'(sb.size() < 2));
        check_eq("p_srdy", 32'(p_srdy), 32'(sb.size() > 0));
        check_eq("c_drdy_n", 32'(c_drdy_n), 32'(sb.size() < 2));
        check_eq("p_srdy_n", 32'(p_srdy_n), 32'(sb.size() > 0));
        check_eq("cnt0", 32'(cnt0), 32'(sat(m_n0, 65535)));
        check_eq("cnt1", 32'(cnt1), 32'(sat(m_n1, 65535)));
        check_eq("err_grant", 32'(err_grant), 32'(m_err));
        check_eq("cnt0_n", 32'(cnt0_n), 32'(sat(m_n0, 3)));
        check_eq("cnt1_n", 32'(cnt1_n), 32'(sat(m_n1, 3)));
        check_eq("err_grant_n", 32'(err_grant_n), 32'(m_err));
        if (!reset) begin
            if (p_srdy && p_drdy) begin
                if (sb.size() == 0) begin
                    check_eq("pop_empty", 32'(sb.size()), 32'd1);
                end else begin
                    exp_beat = sb.pop_front();
                    check_eq("p_data", 32'(p_data), 32'(exp_beat[7:0]));
                    check_eq("p_src", 32'(p_src), 32'(exp_beat[8]));
                    check_eq("p_data_n", 32'(p_data_n), 32'(exp_beat[7:0]));
                    check_eq("p_src_n", 32'(p_src_n), 32'(exp_beat[8]));
                end
            end
            if (c_srdy && c_drdy) begin
                sb.push_back({(c_grant == 2'b10), c_data});
                if (!cnt_clr) begin
                    if (c_grant == 2'b01) m_n0++;
                    else if (c_grant == 2'b10) m_n1++;
                    else m_err = 1'b1;
                end
            end
            if (cnt_clr) begin
                m_n0  = 0;
                m_n1  = 0;
                m_err = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer a beat and hold it until accepted (bounded).
    task automatic send(input logic [7:0] d, input logic [1:0] g);
        bit done;
        done    = 1'b0;
        c_srdy  = 1'b1;
        c_data  = d;
        c_grant = g;
        for (int i = 0; i < 20 && !done; i++) begin
            done = c_drdy;
            @(posedge clk);
            #1;
        end
        if (!done) check_eq("send_timeout", 32'(done), 32'd1);
        c_srdy  = 1'b0;
        c_grant = 2'b00;
    endtask

    initial begin
        int c0_save, c1_save;
        reset   = 1'b1;
        c_srdy  = 1'b0;
        c_data  = 8'h00;
        c_grant = 2'b00;
        p_drdy  = 1'b0;
        cnt_clr = 1'b0;
        idle(2);
        check_eq("rst_p_srdy", 32'(p_srdy), 32'd0);
        check_eq("rst_p_data", 32'(p_data), 32'd0);
        check_eq("rst_p_src", 32'(p_src), 32'd0);
        check_eq("rst_c_drdy", 32'(c_drdy), 32'd1);
        check_eq("rst_cnt0", 32'(cnt0), 32'd0);
        check_eq("rst_err", 32'(err_grant), 32'd0);
        reset = 1'b0;
        idle(1);

        // Single beat
        p_drdy = 1'b1;
        send(8'hA5, 2'b01);
        check_eq("single_p_srdy", 32'(p_srdy), 32'd1);
        check_eq("single_p_data", 32'(p_data), 32'hA5);
        check_eq("single_p_src", 32'(p_src), 32'd0);
        check_eq("single_cnt0", 32'(cnt0), 32'd1);
        check_eq("single_cnt1", 32'(cnt1), 32'd0);
        idle(2);

        // Backpressure
        p_drdy = 1'b0;
        send(8'h11, 2'b10);
        send(8'h22, 2'b01);
        check_eq("bp_full", 32'(c_drdy), 32'd0);
        c_srdy  = 1'b1;
        c_data  = 8'h33;
        c_grant = 2'b01;
        idle(3);
        check_eq("bp_held_off", 32'(c_drdy), 32'd0);
        check_eq("bp_hold_data", 32'(p_data), 32'h11);
        check_eq("bp_hold_src", 32'(p_src), 32'd1);
        p_drdy = 1'b1;
        send(8'h33, 2'b01);
        idle(4);
        check_eq("bp_drain", 32'(sb.size()), 32'd0);

        // Streaming
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_eq("stream_not_full", 32'(c_drdy), 32'd1);
            send(8'h40 + 8'(i), (i % 2 == 1) ? 2'b10 : 2'b01);
        end
        idle(2);
        check_eq("stream_cnt0", 32'(cnt0), 32'd4);
        check_eq("stream_cnt1", 32'(cnt1), 32'd4);
        check_eq("stream_drain", 32'(sb.size()), 32'd0);

        // Saturation and clear on the narrow instance
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) send(8'h50 + 8'(i), 2'b01);
        check_eq("sat_cnt0_n", 32'(cnt0_n), 32'd3);
        check_eq("sat_cnt0_wide", 32'(cnt0), 32'd5);
        idle(2);
        check_eq("sat_hold", 32'(cnt0_n), 32'd3);
        cnt_clr = 1'b1;
        send(8'h5A, 2'b01);
        cnt_clr = 1'b0;
        check_eq("clr_cnt0_n", 32'(cnt0_n), 32'd0);
        check_eq("clr_cnt0", 32'(cnt0), 32'd0);
        idle(2);
        check_eq("clr_beat_delivered", 32'(sb.size()), 32'd0);

        // Grant error
        send(8'h60, 2'b10);
        c0_save = int'(cnt0);
        c1_save = int'(cnt1);
        send(8'h77, 2'b11);
        check_eq("err_set", 32'(err_grant), 32'd1);
        check_eq("err_cnt0", 32'(cnt0), 32'(c0_save));
        check_eq("err_cnt1", 32'(cnt1), 32'(c1_save));
        idle(3);
        check_eq("err_sticky", 32'(err_grant), 32'd1);
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;
        check_eq("err_clr", 32'(err_grant), 32'd0);

        // Reset mid-stream with the buffer full
        p_drdy = 1'b0;
        send(8'h81, 2'b01);
        send(8'h82, 2'b10);
        check_eq("rst_mid_full", 32'(c_drdy), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_mid_p_srdy", 32'(p_srdy), 32'd0);
        check_eq("rst_mid_cnt0", 32'(cnt0), 32'd0);
        check_eq("rst_mid_cnt1", 32'(cnt1), 32'd0);
        check_eq("rst_mid_c_drdy", 32'(c_drdy), 32'd1);
        check_eq("rst_mid_p_srdy_n", 32'(p_srdy_n), 32'd0);
        idle(2);
        reset = 1'b0;
        check_eq("rst_rel_c_drdy", 32'(c_drdy), 32'd1);
        p_drdy = 1'b1;
        send(8'h99, 2'b10);
        check_eq("rst_rel_p_srdy", 32'(p_srdy), 32'd1);
        check_eq("rst_rel_p_data", 32'(p_data), 32'h99);
        check_eq("rst_rel_p_src", 32'(p_src), 32'd1);
        idle(3);
        check_eq("final_drain", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
